// File: rtl/bus_pkg.sv
// Shared bus-datapath definitions: source/destination index map, request opcodes,
// sequencer states and the request legality rules.
package bus_pkg;

    localparam int unsigned NSRC_DEF = 32;
    localparam int unsigned FNW_DEF  = 5;
    localparam int unsigned IDX_W    = 5;

    // Bus encoder index map
    localparam logic [IDX_W-1:0] R0     = 5'd0;
    localparam logic [IDX_W-1:0] R1     = 5'd1;
    localparam logic [IDX_W-1:0] R2     = 5'd2;
    localparam logic [IDX_W-1:0] R3     = 5'd3;
    localparam logic [IDX_W-1:0] R4     = 5'd4;
    localparam logic [IDX_W-1:0] R5     = 5'd5;
    localparam logic [IDX_W-1:0] R6     = 5'd6;
    localparam logic [IDX_W-1:0] R7     = 5'd7;
    localparam logic [IDX_W-1:0] R8     = 5'd8;
    localparam logic [IDX_W-1:0] R9     = 5'd9;
    localparam logic [IDX_W-1:0] R10    = 5'd10;
    localparam logic [IDX_W-1:0] R11    = 5'd11;
    localparam logic [IDX_W-1:0] R12    = 5'd12;
    localparam logic [IDX_W-1:0] R13    = 5'd13;
    localparam logic [IDX_W-1:0] R14    = 5'd14;
    localparam logic [IDX_W-1:0] R15    = 5'd15;
    localparam logic [IDX_W-1:0] HI     = 5'd16;
    localparam logic [IDX_W-1:0] LO     = 5'd17;
    localparam logic [IDX_W-1:0] ZHI    = 5'd18;
    localparam logic [IDX_W-1:0] ZLO    = 5'd19;
    localparam logic [IDX_W-1:0] PC     = 5'd20;
    localparam logic [IDX_W-1:0] MDR    = 5'd21;
    localparam logic [IDX_W-1:0] INPORT = 5'd22;
    localparam logic [IDX_W-1:0] CSEXT  = 5'd23;

    typedef enum logic [1:0] {
        OP_MOVE     = 2'd0,
        OP_ALU      = 2'd1,
        OP_ALU_WIDE = 2'd2,
        OP_ILLEGAL  = 2'd3
    } req_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MOVE  = 3'd1,
        S_ALU_A = 3'd2,
        S_ALU_B = 3'd3,
        S_WB_LO = 3'd4,
        S_WB_HI = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    function automatic logic src_ok(input logic [IDX_W-1:0] idx);
        return idx <= CSEXT;
    endfunction

    // Only true registers may be loaded; Z halves, InPort and C_sign_ext are read-only
    function automatic logic dst_ok(input logic [IDX_W-1:0] idx);
        return (idx <= LO) || (idx == PC) || (idx == MDR);
    endfunction

    function automatic logic req_legal(input req_op_e op, input logic [IDX_W-1:0] src_a,
                                       input logic [IDX_W-1:0] src_b, input logic [IDX_W-1:0] dst);
        logic ok;
        ok = (op != OP_ILLEGAL) && src_ok(src_a);
        if (op != OP_MOVE)     ok = ok && src_ok(src_b);
        if (op != OP_ALU_WIDE) ok = ok && dst_ok(dst);
        return ok;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; all-zero output when disabled.
module onehot_dec #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 5
) (
    input  logic         en_i,
    input  logic [W-1:0] idx_i,
    output logic [N-1:0] dec_o
);

    assign dec_o = en_i ? (N'(1) << idx_i) : '0;

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Expands one register-transfer request at a time into per-cycle bus source,
// register load and Y/Z strobes, with at most one bus driver per cycle.
module bus_transfer_sequencer
    import bus_pkg::*;
#(
    parameter int unsigned NSRC = NSRC_DEF,
    parameter int unsigned FNW  = FNW_DEF
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [4:0]      req_src_a,
    input  logic [4:0]      req_src_b,
    input  logic [4:0]      req_dst,
    input  logic [FNW-1:0]  req_fn,
    output logic [NSRC-1:0] bus_out_en,
    output logic [NSRC-1:0] reg_in_en,
    output logic            y_in,
    output logic            z_in,
    output logic [FNW-1:0]  alu_fn,
    output logic            done,
    output logic            err
);

    state_e           state_q, state_d;
    req_op_e          op_q, op_d;
    logic [IDX_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
    logic [FNW-1:0]   fn_q, fn_d;

    logic [IDX_W-1:0] bus_idx_d, reg_idx_d;
    logic             bus_vld_d, reg_vld_d;
    logic [NSRC-1:0]  bus_en_d, reg_en_d;
    logic             ready_d, y_d, z_d, done_d, err_d;
    logic [FNW-1:0]   alu_fn_d;

    // Next state and request capture
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        dst_d   = dst_q;
        fn_d    = fn_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op_e'(req_op);
                    src_a_d = req_src_a;
                    src_b_d = req_src_b;
                    dst_d   = req_dst;
                    fn_d    = req_fn;
                    if (!req_legal(req_op_e'(req_op), req_src_a, req_src_b, req_dst))
                        state_d = S_ERR;
                    else if (req_op_e'(req_op) == OP_MOVE)
                        state_d = S_MOVE;
                    else
                        state_d = S_ALU_A;
                end
            end
            S_ALU_A: state_d = S_ALU_B;
            S_ALU_B: state_d = S_WB_LO;
            S_WB_LO: state_d = (op_q == OP_ALU_WIDE) ? S_WB_HI : S_IDLE;
            S_MOVE, S_WB_HI, S_ERR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered without added latency
    always_comb begin
        bus_idx_d = '0;
        bus_vld_d = 1'b0;
        reg_idx_d = '0;
        reg_vld_d = 1'b0;
        ready_d   = 1'b0;
        y_d       = 1'b0;
        z_d       = 1'b0;
        alu_fn_d  = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_d)
            S_IDLE: ready_d = 1'b1;
            S_MOVE: begin
                bus_idx_d = src_a_d;
                bus_vld_d = 1'b1;
                reg_idx_d = dst_d;
                reg_vld_d = 1'b1;
                done_d    = 1'b1;
            end
            S_ALU_A: begin
                bus_idx_d = src_a_d;
                bus_vld_d = 1'b1;
                y_d       = 1'b1;
            end
            S_ALU_B: begin
                bus_idx_d = src_b_d;
                bus_vld_d = 1'b1;
                alu_fn_d  = fn_d;
                z_d       = 1'b1;
            end
            S_WB_LO: begin
                bus_idx_d = ZLO;
                bus_vld_d = 1'b1;
                reg_idx_d = (op_d == OP_ALU_WIDE) ? LO : dst_d;
                reg_vld_d = 1'b1;
                done_d    = (op_d != OP_ALU_WIDE);
            end
            S_WB_HI: begin
                bus_idx_d = ZHI;
                bus_vld_d = 1'b1;
                reg_idx_d = HI;
                reg_vld_d = 1'b1;
                done_d    = 1'b1;
            end
            S_ERR:   err_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    onehot_dec #(.N(NSRC), .W(IDX_W)) u_bus_dec (
        .en_i  (bus_vld_d),
        .idx_i (bus_idx_d),
        .dec_o (bus_en_d)
    );

    onehot_dec #(.N(NSRC), .W(IDX_W)) u_reg_dec (
        .en_i  (reg_vld_d),
        .idx_i (reg_idx_d),
        .dec_o (reg_en_d)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MOVE;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dst_q      <= '0;
            fn_q       <= '0;
            req_ready  <= 1'b1;
            bus_out_en <= '0;
            reg_in_en  <= '0;
            y_in       <= 1'b0;
            z_in       <= 1'b0;
            alu_fn     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            dst_q      <= dst_d;
            fn_q       <= fn_d;
            req_ready  <= ready_d;
            bus_out_en <= bus_en_d;
            reg_in_en  <= reg_en_d;
            y_in       <= y_d;
            z_in       <= z_d;
            alu_fn     <= alu_fn_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Randomized bench for bus_transfer_sequencer against a queue-of-expected-cycles
// reference model built directly from each accepted request.
module tb_bus_transfer_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_src_a, req_src_b, req_dst;
    logic [4:0]  req_fn;
    logic [31:0] bus_out_en, reg_in_en;
    logic        y_in, z_in, done, err;
    logic [4:0]  alu_fn;

    bus_transfer_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src_a  (req_src_a),
        .req_src_b  (req_src_b),
        .req_dst    (req_dst),
        .req_fn     (req_fn),
        .bus_out_en (bus_out_en),
        .reg_in_en  (reg_in_en),
        .y_in       (y_in),
        .z_in       (z_in),
        .alu_fn     (alu_fn),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] bus;
        logic [31:0] rg;
        logic        y;
        logic        z;
        logic [4:0]  fn;
        logic        dn;
        logic        er;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;
    int   dones = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] bus, input logic [31:0] rg, input logic y,
                                input logic z, input logic [4:0] fn, input logic dn, input logic er);
        exp_t e;
        e.bus = bus; e.rg = rg; e.y = y; e.z = z; e.fn = fn; e.dn = dn; e.er = er; e.rdy = 1'b0;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e = mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        e.rdy = 1'b1;
        return e;
    endfunction

    // Expected cycles following the accept edge, straight from the transfer rules
    task automatic push_seq(input int op, input int a, input int b, input int d, input logic [4:0] fn);
        bit legal;
        bit dst_good;
        dst_good = (d <= 17) || (d == 20) || (d == 21);
        legal = (op != 3) && (a < 24) && ((op == 0) || (b < 24)) && ((op == 2) || dst_good);
        if (!legal) begin
            exp_q.push_back(mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1));
        end else if (op == 0) begin
            exp_q.push_back(mk(32'd1 << a, 32'd1 << d, 1'b0, 1'b0, '0, 1'b1, 1'b0));
        end else begin
            exp_q.push_back(mk(32'd1 << a, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0));
            exp_q.push_back(mk(32'd1 << b, '0, 1'b0, 1'b1, fn, 1'b0, 1'b0));
            if (op == 1) begin
                exp_q.push_back(mk(32'd1 << 19, 32'd1 << d, 1'b0, 1'b0, '0, 1'b1, 1'b0));
            end else begin
                exp_q.push_back(mk(32'd1 << 19, 32'd1 << 17, 1'b0, 1'b0, '0, 1'b0, 1'b0));
                exp_q.push_back(mk(32'd1 << 18, 32'd1 << 16, 1'b0, 1'b0, '0, 1'b1, 1'b0));
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic [4:0] fn);
        req_valid = v; req_op = op; req_src_a = a; req_src_b = b; req_dst = d; req_fn = fn;
    endtask

    // One clock: advance the model at the edge, then compare every output
    task automatic step();
        @(posedge clk);
        if (clr) begin
            exp_q.delete();
            cur = idle_exp();
        end else begin
            if (cur.rdy && req_valid) begin
                accepts++;
                push_seq(int'(req_op), int'(req_src_a), int'(req_src_b), int'(req_dst), req_fn);
            end
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_exp();
        end
        #1;
        check_eq("bus_out_en", bus_out_en, cur.bus);
        check_eq("reg_in_en", reg_in_en, cur.rg);
        check_eq("y_in", 32'(y_in), 32'(cur.y));
        check_eq("z_in", 32'(z_in), 32'(cur.z));
        check_eq("alu_fn", 32'(alu_fn), 32'(cur.fn));
        check_eq("done", 32'(done), 32'(cur.dn));
        check_eq("err", 32'(err), 32'(cur.er));
        check_eq("req_ready", 32'(req_ready), 32'(cur.rdy));
        check_eq("bus_onehot", 32'($countones(bus_out_en) <= 1), 32'd1);
        check_eq("reg_onehot", 32'($countones(reg_in_en) <= 1), 32'd1);
        if (done === 1'b1) dones++;
    endtask

    task automatic idle_cycles(input int n);
        drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [4:0] dst_pool[11];

    initial begin
        cur = idle_exp();
        clr = 1'b1;
        drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        clr = 1'b0;
        step();

        // MOVE R3 -> R7
        drive(1'b1, 2'd0, 5'd3, 5'd0, 5'd7, 5'd0);
        step();
        drive(1'b1, 2'd1, 5'd9, 5'd9, 5'd9, 5'd9);
        check_eq("move_bus_lit", bus_out_en, 32'h8);
        check_eq("move_reg_lit", reg_in_en, 32'h80);
        req_valid = 1'b0;
        idle_cycles(2);

        // ALU R1,R2 -> R5 fn 4, then ALU_WIDE R4,R6
        drive(1'b1, 2'd1, 5'd1, 5'd2, 5'd5, 5'h04);
        step();
        req_valid = 1'b0;
        idle_cycles(4);
        drive(1'b1, 2'd2, 5'd4, 5'd6, 5'd31, 5'h0a);
        step();
        idle_cycles(3);
        check_eq("wide_hi_bus_lit", bus_out_en, 32'h40000);
        check_eq("wide_hi_reg_lit", reg_in_en, 32'h10000);
        idle_cycles(2);

        // Illegal: MOVE to Z_LO, then op 3
        drive(1'b1, 2'd0, 5'd2, 5'd0, 5'd19, 5'd0);
        step();
        idle_cycles(2);
        drive(1'b1, 2'd3, 5'd1, 5'd2, 5'd3, 5'd1);
        step();
        idle_cycles(2);

        // clr during the ALU_B cycle aborts the transfer
        drive(1'b1, 2'd1, 5'd8, 5'd9, 5'd10, 5'h11);
        step();
        idle_cycles(1);
        check_eq("in_alu_b", 32'(z_in), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle_cycles(5);
        drive(1'b1, 2'd0, 5'd20, 5'd0, 5'd21, 5'd0);
        step();
        idle_cycles(2);

        // clr together with req_valid is not an accept
        clr = 1'b1;
        drive(1'b1, 2'd0, 5'd1, 5'd0, 5'd2, 5'd0);
        step();
        clr = 1'b0;
        idle_cycles(2);

        // Random back-to-back legal requests with req_valid held high
        dst_pool = '{5'd0, 5'd3, 5'd7, 5'd11, 5'd15, 5'd16, 5'd17, 5'd20, 5'd21, 5'd9, 5'd12};
        accepts = 0;
        dones = 0;
        for (int i = 0; i < 400; i++) begin
            drive(1'b1, 2'($urandom_range(0, 2)), 5'($urandom_range(0, 23)), 5'($urandom_range(0, 23)),
                  dst_pool[$urandom_range(0, 10)], 5'($urandom));
            step();
        end
        idle_cycles(6);
        check_eq("done_vs_accept", 32'(dones), 32'(accepts));

        // Fully random requests, including illegal ones and sporadic clr
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 39) == 0);
            drive(1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            step();
        end
        clr = 1'b0;
        idle_cycles(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_transfer_sequencer.md
# bus_transfer_sequencer

Sequences register-transfer micro-operations on the shared 32-source datapath bus. It accepts one transfer request at a time over a valid/ready handshake. Each request is expanded into a fixed per-cycle sequence of one-hot bus-source enables (to the bus encoder), register load enables, and Y/Z latch strobes. It guarantees at most one bus driver per cycle and sits between the control unit and the datapath.

## Interface
Parameters:
- `NSRC`, 32, number of bus sources/destinations; index map is the bus encoder's: 0–15 R0–R15, 16 HI, 17 LO, 18 Z_HI, 19 Z_LO, 20 PC, 21 MDR, 22 InPort, 23 C_sign_ext, 24–31 unused
- `FNW`, 5, ALU function code width

Ports:
- `clk`  in  1  sole clock, rising edge
- `clr`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept
- `req_op`  in  2  0 MOVE, 1 ALU, 2 ALU_WIDE (result to LO and HI), 3 illegal
- `req_src_a`  in  5  first source index
- `req_src_b`  in  5  second source index (ALU ops only)
- `req_dst`  in  5  destination index (MOVE/ALU; ignored for ALU_WIDE)
- `req_fn`  in  FNW  ALU function code
- `bus_out_en`  out  NSRC  one-hot-or-zero source enables to the encoder
- `reg_in_en`  out  NSRC  one-hot-or-zero load enables
- `y_in`  out  1  load Y from bus
- `z_in`  out  1  load Z from ALU
- `alu_fn`  out  FNW  function code to ALU
- `done`  out  1  one-cycle pulse, transfer complete
- `err`  out  1  one-cycle pulse, illegal request rejected

## Operation
- Request capture: accept when `req_valid && req_ready` at a rising edge. Capture op, src_a, src_b, dst and fn into internal registers. Later changes on the `req_*` inputs have no effect.
- Legality check at accept:
  - `req_op`=3 is illegal.
  - `req_src_a` in 24–31 is illegal.
  - For ALU ops, `req_src_b` in 24–31 is illegal.
  - For MOVE/ALU, `req_dst` in {18,19,22,23,24–31} is illegal.
  - An illegal request is still accepted. The FSM enters ERR, with no enables asserted.
- States and their outputs (all other outputs are 0):
  - IDLE: `req_ready`=1.
  - MOVE: `bus_out_en[src_a]`, `reg_in_en[dst]`, `done`. Next state IDLE.
  - ALU_A: `bus_out_en[src_a]`, `y_in`. Next state ALU_B.
  - ALU_B: `bus_out_en[src_b]`, `alu_fn`=fn, `z_in`. Next state WB_LO.
  - WB_LO:
    - ALU: `bus_out_en[19]`, `reg_in_en[dst]`, `done`, then IDLE.
    - ALU_WIDE: `bus_out_en[19]`, `reg_in_en[17]`, then WB_HI.
  - WB_HI: `bus_out_en[18]`, `reg_in_en[16]`, `done`. Next state IDLE.
  - ERR: `err`. Next state IDLE.
- `alu_fn` is 0 in every state except ALU_B.
- Invariant: `$countones(bus_out_en) <= 1` and `$countones(reg_in_en) <= 1` in every cycle.
- src==dst on MOVE is legal: the register reloads its own value.

## Timing
- All outputs are Moore outputs, decoded from the registered state and the captured fields. No combinational path from `req_*` to any output except none; `req_ready` depends on state only.
- Reset: state IDLE, captured fields 0. Outputs after reset: `req_ready`=1, all others 0.
- Latency from the accept edge to the `done` cycle:
  - MOVE: 1 cycle.
  - ALU: 3 cycles.
  - ALU_WIDE: 4 cycles.
  - ERR: `err` is asserted 1 cycle after accept.
- `req_ready` is low from the cycle after accept through the `done`/`err` cycle. It returns high the following cycle. Peak throughput is one MOVE per 2 cycles.
- `clr` mid-sequence: the next cycle is IDLE with all enables 0. No `done` or `err` is produced, and the captured request is discarded. `clr` together with `req_valid` means the request is not accepted.

## Structure
- Shared package `bus_pkg` holds:
  - the source/destination index constants (R0..R15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, CSEXT=23);
  - the `req_op` enum;
  - the FSM state enum;
  - the `NSRC`/`FNW` defaults.
- One sub-module, `onehot_dec`: a 5-to-32 decoder with enable. Instantiate it twice, once for `bus_out_en` and once for `reg_in_en`.

## Test plan
- After `clr`: MOVE src_a=3, dst=7 accepted at edge N. At N+1: `bus_out_en`=0x8, `reg_in_en`=0x80, `done`=1. At N+2: `req_ready`=1.
- ALU src_a=1, src_b=2, dst=5, fn=0x04:
  - N+1: `bus_out_en`=0x2 and `y_in`.
  - N+2: `bus_out_en`=0x4, `alu_fn`=0x04, `z_in`.
  - N+3: `bus_out_en`=0x80000 and `reg_in_en`=0x20 with `done`.
- ALU_WIDE src_a=4, src_b=6:
  - N+3: `bus_out_en`=0x80000 and `reg_in_en`=0x20000, no `done`.
  - N+4: `bus_out_en`=0x40000 and `reg_in_en`=0x10000 with `done`.
- Illegal requests: MOVE dst=19, and separately op=3. For each, `err`=1 at N+1, all enables 0, `req_ready`=1 at N+2.
- `clr` asserted in the ALU_B cycle: next cycle all outputs are at reset values, no `done` is ever produced, and a fresh MOVE is then accepted normally.
- Random back-to-back legal requests with `req_valid` held high: one-hot invariants are never violated, and the `done` count equals the accept count.
